dtree_walk_ctrl: RTL and testbench
==================================

Name: dtree_walk_ctrl

Overview:
- Sequential controller that evaluates a programmable axis-aligned decision tree one node per cycle, sharing a single threshold comparator across all tree levels.
- Hardware-cheap alternative to the fully unrolled combinational classifiers. Sits between the feature-capture front end and the class consumer.
- The node table is written through a config port; samples enter and classes leave through valid/ready handshakes.

Parameters:
- N_FEAT, 6, number of input features.
- FEAT_W, 8, bits per feature.
- CLASS_W, 2, class label width.
- NODE_AW, 5, node address width (2^NODE_AW table entries).
- MAX_DEPTH, 16, maximum non-leaf nodes visited before abort.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  node-table write strobe.
- cfg_addr  in  NODE_AW  node index to write.
- cfg_wdata  in  NODE_W  node word, where NODE_W = 1+3+3+FEAT_W+2*NODE_AW (25 at defaults).
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- in_valid  in  1  sample offered.
- in_ready  out  1  controller can accept a sample.
- in_feat  in  N_FEAT*FEAT_W  packed features; feature i occupies bits [i*FEAT_W +: FEAT_W].
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_class  out  CLASS_W  predicted class.
- out_depth  out  NODE_AW  number of non-leaf nodes traversed.
- out_err  out  1  traversal aborted.

Behaviour:
- Node word, MSB to LSB: leaf[1], feat[3], shift[3], thr[FEAT_W], left[NODE_AW], right[NODE_AW].
- Non-leaf decision: (feature[feat] >> shift) <= thr goes to left, else to right. The compare is unsigned at FEAT_W bits.
- Leaf: class = thr[CLASS_W-1:0]; the other fields are ignored.
- Reset:
  - state IDLE.
  - in_ready=0 during the reset cycle.
  - out_valid=0, out_class=0, out_depth=0, out_err=0, cfg_err=0.
  - Every table entry is set to leaf, class 0, all other fields zero.
- FSM has three states: IDLE, WALK, DONE.
- IDLE:
  - in_ready = !cfg_we.
  - A cfg_we write completes at this edge.
  - in_valid && in_ready at edge E0: latch in_feat, ptr<=0, depth<=0, go to WALK.
- WALK, one node per cycle, evaluating node[ptr] read combinationally from the register table:
  - Leaf: class latched, out_depth<=depth, out_err<=0, go to DONE.
  - Non-leaf with feat >= N_FEAT: out_err<=1, class 0, go to DONE.
  - Non-leaf with depth == MAX_DEPTH-1: out_err<=1, class 0, out_depth<=MAX_DEPTH, go to DONE.
  - Otherwise: ptr<=child, depth<=depth+1.
- DONE:
  - out_valid=1; out_class, out_depth and out_err are held stable until out_ready.
  - out_valid && out_ready: out_valid<=0, go to IDLE. No same-cycle acceptance of the next sample.
- Latency and throughput:
  - A leaf at depth d raises out_valid at edge E0+d+1.
  - Minimum sample period is d+3 cycles (including the IDLE cycle).
- cfg_we outside IDLE: the write is ignored and cfg_err pulses for one cycle. This keeps the table stable during a walk.
- Writes to any address are legal, including re-writing node 0 between samples.
- Cycles are allowed in the table; the MAX_DEPTH abort bounds them.
- rst mid-WALK or mid-DONE: the in-flight result is discarded (out_valid=0 next cycle) and the table is reinitialised.
- The feature register is not modified after capture; changes on in_feat during WALK have no effect.

Test Plan:
- Reset, then offer in_valid with any features -> out_valid at E0+1, class 0, depth 0, err 0; default table is a single leaf.
- Program three nodes:
  - node0: feat5, shift4, thr1, left1, right2.
  - node1: leaf class 1.
  - node2: leaf class 3.
  - X5=0x1F -> class 1, depth 1, out_valid at E0+2.
  - X5=0x20 -> class 3, depth 1.
- Same tree with out_ready held low 5 cycles -> out_valid, class and depth stable for all 5 cycles; in_ready=0 throughout; IDLE is reached one cycle after the out_ready handshake.
- node0 = non-leaf, left=0, right=0 (self loop) -> out_err=1, class 0, out_depth=16, out_valid at E0+16. Separately, node0 feat=7 -> out_err=1 at E0+1.
- cfg_we pulsed during WALK -> cfg_err=1 for one cycle; the target node is unchanged and the current walk result matches the pre-write tree. cfg_we and in_valid asserted together in IDLE -> in_ready=0, write lands, sample accepted next cycle.
- rst asserted in the second WALK cycle -> out_valid never rises for that sample; in_ready=1 one cycle after rst drops; the table reads back as leaf class 0.

Source files
------------

// File: rtl/dtree_walk_ctrl.sv
// dtree_walk_ctrl
//   Sequential decision-tree evaluator. It visits one node per cycle from a
//   register node table and shares a single threshold comparator across all
//   tree levels. The table is written through a config port while idle.
//   Samples enter and classes leave through valid/ready handshakes.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   cfg_we/addr/wdata   node-table write; cfg_err pulses when a write is rejected
//   in_valid/ready/feat sample handshake; feature i at [i*FEAT_W +: FEAT_W]
//   out_valid/ready     result handshake
//   out_class           predicted class (0 on abort)
//   out_depth           number of non-leaf nodes traversed
//   out_err             traversal aborted (bad feature index or depth limit)
//
// Node word, MSB..LSB: leaf, feat[3], shift[3], thr[FEAT_W], left, right.
module dtree_walk_ctrl #(
  parameter int N_FEAT    = 6,
  parameter int FEAT_W    = 8,
  parameter int CLASS_W   = 2,
  parameter int NODE_AW   = 5,
  parameter int MAX_DEPTH = 16,
  localparam int NODE_W   = 1 + 3 + 3 + FEAT_W + 2*NODE_AW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic [NODE_AW-1:0]       out_depth,
  output logic                     out_err
);

  typedef struct packed {
    logic               leaf;
    logic [2:0]         feat;
    logic [2:0]         shift;
    logic [FEAT_W-1:0]  thr;
    logic [NODE_AW-1:0] left;
    logic [NODE_AW-1:0] right;
  } node_t;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                  state, state_nx;
  logic [NODE_W-1:0]       tbl [2**NODE_AW];
  logic [N_FEAT*FEAT_W-1:0] feat_r;
  logic [NODE_AW-1:0]      ptr, depth;
  node_t                   nd;
  logic [FEAT_W-1:0]       fsel, fsh;
  logic                    go_left, bad_feat, too_deep, accept, finish;

  // Current node, read combinationally; the single shared comparator.
  assign nd       = node_t'(tbl[ptr]);
  assign bad_feat = int'(nd.feat) >= N_FEAT;
  assign too_deep = int'(depth) == MAX_DEPTH-1;
  assign fsh      = fsel >> nd.shift;
  assign go_left  = fsh <= nd.thr;
  assign finish   = nd.leaf || bad_feat || too_deep;

  // Feature mux; out-of-range indices select zero and are flagged by bad_feat.
  always_comb begin
    fsel = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (int'(nd.feat) == i) fsel = feat_r[i*FEAT_W +: FEAT_W];
  end

  assign out_valid = (state == DONE);
  assign accept    = (state == IDLE) && in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A pending write in IDLE takes priority over a new sample that cycle.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = !cfg_we && !rst;
        if (in_valid && !cfg_we) state_nx = WALK;
      end
      WALK:    if (finish)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**NODE_AW; i++)
        tbl[i] <= {1'b1, {(NODE_W-1){1'b0}}};
      feat_r    <= '0;
      ptr       <= '0;
      depth     <= '0;
      out_class <= '0;
      out_depth <= '0;
      out_err   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      // Table is frozen outside IDLE so a walk always sees one consistent tree.
      cfg_err <= cfg_we && (state != IDLE);
      if (cfg_we && state == IDLE) tbl[cfg_addr] <= cfg_wdata;
      case (state)
        IDLE: if (accept) begin
          feat_r <= in_feat;
          ptr    <= '0;
          depth  <= '0;
        end
        WALK: begin
          if (nd.leaf) begin
            out_class <= nd.thr[CLASS_W-1:0];
            out_depth <= depth;
            out_err   <= 1'b0;
          end else if (bad_feat) begin
            out_class <= '0;
            out_depth <= depth;
            out_err   <= 1'b1;
          end else if (too_deep) begin
            out_class <= '0;
            out_depth <= NODE_AW'(MAX_DEPTH);
            out_err   <= 1'b1;
          end else begin
            ptr   <= go_left ? nd.left : nd.right;
            depth <= depth + NODE_AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_walk_ctrl.sv
// Directed bench for dtree_walk_ctrl with a scoreboard fed by a software
// tree-walk model over a mirror of the node table.
module tb_dtree_walk_ctrl;
  localparam int NF = 6, FW = 8, CW = 2, AW = 5, MD = 16;
  localparam int NW = 1 + 3 + 3 + FW + 2*AW;

  logic           clk, rst, cfg_we, cfg_err;
  logic [AW-1:0]  cfg_addr;
  logic [NW-1:0]  cfg_wdata;
  logic           in_valid, in_ready, out_valid, out_ready, out_err;
  logic [NF*FW-1:0] in_feat;
  logic [CW-1:0]  out_class;
  logic [AW-1:0]  out_depth;

  typedef struct {
    logic [CW-1:0] cls;
    logic [AW-1:0] dep;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          sbq[$];
  logic [NW-1:0] mtbl [2**AW];
  int            checks = 0, failures = 0;

  dtree_walk_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .in_valid(in_valid),
    .in_ready(in_ready), .in_feat(in_feat), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_depth(out_depth),
    .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] mk(input int lf, input int f, input int sh,
                                       input int thr, input int l, input int r);
    return {1'(lf), 3'(f), 3'(sh), 8'(thr), 5'(l), 5'(r)};
  endfunction

  function automatic void mirror_reset();
    for (int i = 0; i < 2**AW; i++) mtbl[i] = mk(1, 0, 0, 0, 0, 0);
  endfunction

  // Reference walk: latency counts edges from acceptance to out_valid.
  function automatic exp_t model(input logic [NF*FW-1:0] x);
    exp_t e;
    int p, d, ft, sh, th, v;
    logic [NW-1:0] n;
    e.cls = '0; e.dep = '0; e.err = 1'b0; e.lat = 0;
    p = 0; d = 0;
    for (int k = 0; k < 64; k++) begin
      n  = mtbl[p];
      ft = int'(n[23:21]);
      sh = int'(n[20:18]);
      th = int'(n[17:10]);
      if (n[24]) begin
        e.cls = n[11:10]; e.dep = AW'(d); e.lat = d + 1; return e;
      end
      if (ft >= NF) begin
        e.err = 1'b1; e.dep = AW'(d); e.lat = d + 1; return e;
      end
      if (d == MD-1) begin
        e.err = 1'b1; e.dep = AW'(MD); e.lat = d + 1; return e;
      end
      v = int'(x[ft*FW +: FW]) >> sh;
      p = (v <= th) ? int'(n[9:5]) : int'(n[4:0]);
      d++;
    end
    return e;
  endfunction

  task automatic write_node(input int a, input logic [NW-1:0] w);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = w;
    @(negedge clk);
    cfg_we = 1'b0;
    mtbl[a] = w;
  endtask

  // Ends on the falling edge right after the accepting edge.
  task automatic offer(input logic [NF*FW-1:0] f);
    int n;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    chk("offer_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_feat = f;
    sbq.push_back(model(f));
    @(negedge clk);
    in_valid = 1'b0;
    in_feat  = ~f;  // must not disturb the walk
  endtask

  task automatic collect(input int hold, input int lat0);
    int lat;
    exp_t e;
    lat = lat0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() == 0) return;
    e = sbq.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_class", 32'(out_class), 32'(e.cls));
      chk("hold_depth", 32'(out_depth), 32'(e.dep));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_class", 32'(out_class), 32'(e.cls));
    chk("out_depth", 32'(out_depth), 32'(e.dep));
    chk("out_err",   32'(out_err),   32'(e.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    in_valid = 1'b0; in_feat = '0; out_ready = 1'b0;
    mirror_reset();

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("rst_in_ready2", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_class", 32'(out_class), 32'd0);
    chk("rst_out_depth", 32'(out_depth), 32'd0);
    chk("rst_out_err",   32'(out_err),   32'd0);
    chk("rst_cfg_err",   32'(cfg_err),   32'd0);
    rst = 1'b0;

    // Default table: a single class-0 leaf
    offer(48'hA5A5_1234_5678);
    collect(0, 0);

    // Three-node tree on feature 5 >> 4 vs 1
    write_node(0, mk(0, 5, 4, 1, 1, 2));
    write_node(1, mk(1, 0, 0, 1, 0, 0));
    write_node(2, mk(1, 0, 0, 3, 0, 0));
    chk("cfg_err_idle", 32'(cfg_err), 32'd0);
    offer({8'h1F, 40'h0});
    collect(0, 0);
    offer({8'h20, 40'h12_3456_789A});
    collect(0, 0);
    offer({8'h1F, 40'hFF_FFFF_FFFF});
    collect(5, 0);

    // Deeper tree, random features
    write_node(2, mk(0, 0, 0, 8'h80, 3, 4));
    write_node(3, mk(1, 0, 0, 2, 0, 0));
    write_node(4, mk(1, 0, 0, 3, 0, 0));
    for (int i = 0; i < 6; i++) begin
      offer({16'($urandom), 32'($urandom)});
      collect(0, 0);
    end

    // Self loop hits the depth limit
    write_node(0, mk(0, 0, 0, 0, 0, 0));
    offer(48'h0);
    collect(0, 0);

    // Feature index out of range
    write_node(0, mk(0, 7, 0, 0, 1, 2));
    offer(48'h0);
    collect(0, 0);

    // Write during a walk is rejected
    write_node(0, mk(0, 5, 4, 1, 1, 2));
    write_node(2, mk(1, 0, 0, 3, 0, 0));
    offer({8'h1F, 40'h0});
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_wdata = mk(1, 0, 0, 2, 0, 0);
    @(negedge clk);
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("walk_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
    collect(0, 2);
    offer({8'h1F, 40'h0});
    collect(0, 0);

    // Write and sample together in IDLE: write first, sample next cycle
    #1;
    cfg_we = 1'b1; cfg_addr = 5'd2; cfg_wdata = mk(1, 0, 0, 2, 0, 0);
    in_valid = 1'b1; in_feat = {8'h20, 40'h0};
    #1;
    chk("cfgwe_blocks_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    cfg_we = 1'b0;
    mtbl[2] = mk(1, 0, 0, 2, 0, 0);
    #1;
    chk("ready_after_write", 32'(in_ready), 32'd1);
    sbq.push_back(model(in_feat));
    @(negedge clk);
    in_valid = 1'b0;
    collect(0, 0);

    // Reset in the second walk cycle discards the result
    write_node(0, mk(0, 5, 4, 1, 1, 1));
    write_node(1, mk(0, 5, 4, 1, 2, 2));
    offer({8'h1F, 40'h0});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    mirror_reset();
    chk("rst_walk_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_walk_valid_hold", 32'(out_valid), 32'd0);
    end
    chk("rst_walk_in_ready", 32'(in_ready), 32'd1);
    offer({8'h1F, 40'h0});
    collect(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
